spi_mnrch_gen: RTL and testbench

//  Parametrised SPI monarch (master): DATA_W-bit full-duplex transfers, per-transaction SPI mode (CPOL/CPHA)
//  and NUM_SS one-cold serf selects. SCLK is derived from a free-running divider (period 2^DIV_W clk).

---
 rtl/spi_gen_pkg.sv | 23 ++
 rtl/spi_sclk_div.sv | 39 +++
 rtl/spi_mnrch_gen.sv | 142 ++++++++++++++
 tb/tb_spi_mnrch_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_gen_pkg.sv
// Shared types and constants for the SPI monarch: FSM state encoding, SPI mode
// constants and the divider reload value.
package spi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        XFER  = 2'd2,
        BACK  = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Reload sits a quarter period before the first leading edge, so MOSI has
    // settled well before the serf samples it.
    function automatic logic [31:0] sclk_load(input int div_w);
        return 32'((1 << (div_w - 1)) + (1 << (div_w - 2)) - 1);
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Free-running SCLK divider: period 2^DIV_W clk, held at the reload value while
// ld_i is high, with one-cycle-early flags for the leading and trailing edges.
module spi_sclk_div
    import spi_gen_pkg::*;
#(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic lead_imm_o,
    output logic trail_imm_o
);

    localparam logic [DIV_W-1:0] LOAD      = DIV_W'(sclk_load(DIV_W));
    localparam logic [DIV_W-1:0] TRAIL_PRE = {1'b0, {(DIV_W-1){1'b1}}};

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = ld_i ? LOAD : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= LOAD;
        end else begin
            div_q <= div_d;
        end
    end

    assign lead_imm_o  = (div_q == '1);
    assign trail_imm_o = (div_q == TRAIL_PRE);
    assign sclk_o      = cpol_i ? div_q[DIV_W-1] : ~div_q[DIV_W-1];

endmodule

// File: rtl/spi_mnrch_gen.sv
// SPI monarch: DATA_W-bit full-duplex transfers with per-transaction CPOL/CPHA
// and one-cold serf select, handshaked through wrt/done.
//
//  state | meaning
//  IDLE  | divider held at reload, waiting for wrt
//  FRONT | select asserted, waiting for the first capture edge
//  XFER  | capturing MISO / launching MOSI until DATA_W captures
//  BACK  | waiting for the closing edge: final shift, deselect, done
module spi_mnrch_gen
    import spi_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 1,
    localparam int SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrt,
    input  logic [DATA_W-1:0]   wt_data,
    input  logic [1:0]          mode,
    input  logic [SS_IDX_W-1:0] ss_sel,
    input  logic                MISO,
    output logic                SCLK,
    output logic                MOSI,
    output logic [NUM_SS-1:0]   SS_n,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    bit_cntr_q, bit_cntr_d;
    logic                miso_smpl_q, miso_smpl_d;
    logic [DATA_W-1:0]   shft_q, shft_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic lead_imm, trail_imm, cap_imm, launch_imm, div_ld;

    // CPHA picks which divider edge samples MISO; the other one shifts.
    assign cap_imm    = mode_q[0] ? trail_imm : lead_imm;
    assign launch_imm = mode_q[0] ? lead_imm  : trail_imm;
    assign div_ld     = (state_q == IDLE) ||
                        ((state_q == BACK) && (lead_imm || trail_imm));

    spi_sclk_div #(.DIV_W(DIV_W)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_i        (div_ld),
        .cpol_i      (mode_q[1]),
        .sclk_o      (SCLK),
        .lead_imm_o  (lead_imm),
        .trail_imm_o (trail_imm)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bit_cntr_d  = bit_cntr_q;
        miso_smpl_d = miso_smpl_q;
        shft_d      = shft_q;
        ss_n_d      = ss_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (wrt) begin
                    state_d    = FRONT;
                    mode_d     = mode;
                    shft_d     = wt_data;
                    bit_cntr_d = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    ss_n_d     = '1;
                    for (int i = 0; i < NUM_SS; i++) begin
                        if (ss_sel == SS_IDX_W'(i)) ss_n_d[i] = 1'b0;
                    end
                end
            end
            FRONT: begin
                if (cap_imm) begin
                    miso_smpl_d = MISO;
                    bit_cntr_d  = bit_cntr_q + CNT_W'(1);
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (cap_imm) begin
                    miso_smpl_d = MISO;
                    bit_cntr_d  = bit_cntr_q + CNT_W'(1);
                    if (bit_cntr_q == CNT_W'(DATA_W - 1)) state_d = BACK;
                end else if (launch_imm) begin
                    shft_d = {shft_q[DATA_W-2:0], miso_smpl_q};
                end
            end
            BACK: begin
                if (lead_imm || trail_imm) begin
                    shft_d  = {shft_q[DATA_W-2:0], miso_smpl_q};
                    ss_n_d  = '1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE3;
            bit_cntr_q  <= '0;
            miso_smpl_q <= 1'b0;
            shft_q      <= '0;
            ss_n_q      <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cntr_q  <= bit_cntr_d;
            miso_smpl_q <= miso_smpl_d;
            shft_q      <= shft_d;
            ss_n_q      <= ss_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign MOSI    = shft_q[DATA_W-1];
    assign SS_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: tb/tb_spi_mnrch_gen.sv
// Bench for spi_mnrch_gen: a cycle-level transaction model checked every cycle,
// a behavioural SPI serf, and directed transfers with literal expectations.
module tb_spi_mnrch_gen;
    import spi_gen_pkg::*;

    localparam int DATA_W     = 16;
    localparam int DIV_W      = 5;
    localparam int NUM_SS     = 4;
    localparam int P          = 2 ** DIV_W;
    localparam int LOAD_V     = 2 ** (DIV_W - 1) + 2 ** (DIV_W - 2) - 1;
    localparam int FIRST_LEAD = P - LOAD_V + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wrt = 1'b0;
    logic [DATA_W-1:0] wt_data = '0;
    logic [1:0] mode = MODE0;
    logic [1:0] ss_sel = 2'd0;
    logic miso, sclk, mosi, busy, done;
    logic [NUM_SS-1:0] ss_n;
    logic [DATA_W-1:0] rd_data;

    logic ss_sel1 = 1'b1;
    logic sclk1, mosi1, busy1, done1;
    logic [0:0] ss_n1;
    logic [DATA_W-1:0] rd_data1;

    int n_tests = 0;
    int n_fail = 0;

    logic cur_cpol = 1'b1, cur_cpha = 1'b1, loopback = 1'b0;
    logic [15:0] serf_val = '0, s_rx = '0, s_tx = '0;
    int s_caps = 0, s_leads = 0;
    logic s_prev_sclk = 1'b1, s_prev_sel = 1'b0;

    logic m_act = 1'b0, m_done = 1'b0, m_cpol = 1'b1;
    int m_n = 0, m_tdone = 0;
    logic [3:0] m_ssn = 4'hF;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : s_tx[15];

    spi_mnrch_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_SS(NUM_SS)) dut (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .wt_data(wt_data), .mode(mode),
        .ss_sel(ss_sel), .MISO(miso), .SCLK(sclk), .MOSI(mosi), .SS_n(ss_n),
        .busy(busy), .done(done), .rd_data(rd_data)
    );

    // Single-select instance always addressed out of range, looped back on itself.
    spi_mnrch_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_SS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .wt_data(wt_data), .mode(mode),
        .ss_sel(ss_sel1), .MISO(mosi1), .SCLK(sclk1), .MOSI(mosi1), .SS_n(ss_n1),
        .busy(busy1), .done(done1), .rd_data(rd_data1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction model: acceptance only when no transfer is open; a transfer
    // lasts until one half period after the last capture edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_cpol <= 1'b1;
            m_n    <= 0;
            m_ssn  <= 4'hF;
        end else if (!m_act && wrt) begin
            m_act   <= 1'b1;
            m_done  <= 1'b0;
            m_n     <= 1;
            m_cpol  <= mode[1];
            m_tdone <= FIRST_LEAD + (DATA_W - 1) * P + P / 2 + (mode[0] ? P / 2 : 0);
            m_ssn   <= ~(4'b0001 << ss_sel);
        end else if (m_act) begin
            m_n <= m_n + 1;
            if (m_n + 1 == m_tdone) begin
                m_act  <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    initial begin
        logic [6:0] e;
        logic s;
        forever begin
            @(negedge clk);
            s = (m_act && m_n >= FIRST_LEAD && ((m_n - FIRST_LEAD) % P) < P / 2) ? ~m_cpol : m_cpol;
            e = {m_act, m_done, s, (m_act ? m_ssn : 4'hF)};
            chk("cycle_dut", {busy, done, sclk, ss_n}, e);
            chk("cycle_dut1", {busy1, done1, sclk1, ss_n1}, {e[6:4], 1'b1});
        end
    end

    // Serf: captures MOSI on its capture edge, presents its word MSB first and
    // advances on launch edges (the first leading edge in CPHA=1 only opens the frame).
    initial begin
        logic sel, lead;
        forever begin
            @(negedge clk);
            sel = (ss_n != 4'hF);
            if (sel && !s_prev_sel) begin
                s_rx = '0;
                s_tx = serf_val;
                s_caps = 0;
                s_leads = 0;
            end else if (sel && sclk != s_prev_sclk) begin
                lead = (sclk != cur_cpol);
                if (cur_cpha ? !lead : lead) begin
                    s_rx = {s_rx[14:0], mosi};
                    s_caps++;
                end else if (!(lead && s_leads == 0)) begin
                    s_tx = {s_tx[14:0], 1'b0};
                end
                if (lead) s_leads++;
            end
            s_prev_sclk = sclk;
            s_prev_sel = sel;
        end
    end

    task automatic xfer(input string nm, input logic [1:0] md, input logic [15:0] data,
                        input logic [1:0] sel, input logic [3:0] exp_ss, input logic lb,
                        input logic [15:0] sval, input logic [15:0] exp_rd, input int exp_done,
                        input int pulse_a, input int pulse_b, input int rst_at);
        int cyc;
        int first_edge;
        bit fin;
        bit was_rst;
        cur_cpol = md[1];
        cur_cpha = md[0];
        loopback = lb;
        serf_val = sval;
        @(posedge clk); #1;
        wt_data = data; mode = md; ss_sel = sel; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        cyc = 1; first_edge = -1; fin = 0; was_rst = 0;
        chk({nm, ".ss_at_1"}, 32'(ss_n), 32'(exp_ss));
        chk({nm, ".busy_done_at_1"}, {busy, done}, 2'b10);
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            if (first_edge < 0 && sclk != md[1]) first_edge = cyc;
            if (done) begin
                fin = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == pulse_a || cyc == pulse_b) begin
                    wrt = 1'b1; wt_data = ~data; mode = ~md; ss_sel = sel + 2'd1;
                end else begin
                    wrt = 1'b0;
                end
                if (cyc == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk({nm, ".rst_ctrl"}, {busy, done, sclk, ss_n}, 7'b0011111);
                    chk({nm, ".rst_data"}, {mosi, rd_data}, 17'h0);
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                    fin = 1;
                    was_rst = 1;
                end
            end
        end
        wrt = 1'b0;
        if (!fin) begin
            chk({nm, ".timeout"}, 32'(cyc), 32'(exp_done));
        end else if (!was_rst) begin
            chk({nm, ".done_cycle"}, 32'(cyc), 32'(exp_done));
            chk({nm, ".first_edge"}, 32'(first_edge), 32'd10);
            chk({nm, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
            chk({nm, ".serf_rx"}, 32'(s_rx), 32'(data));
            chk({nm, ".captures"}, 32'(s_caps), 32'd16);
            chk({nm, ".rd_data1"}, 32'(rd_data1), 32'(data));
            chk({nm, ".idle_ss"}, {busy, ss_n}, 5'b01111);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, sclk, ss_n}, 7'b0011111);
        chk("reset_data", {mosi, rd_data}, 17'h0);
        chk("reset_dut1", {busy1, done1, sclk1, ss_n1, mosi1}, 5'b00110);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        xfer("m0_loop", MODE0, 16'hA5C3, 2'd0, 4'b1110, 1'b1, 16'h0000, 16'hA5C3, 506, 0, 0, 0);
        xfer("m3_serf", MODE3, 16'h8F00, 2'd2, 4'b1011, 1'b0, 16'h3C5A, 16'h3C5A, 522, 0, 0, 0);
        xfer("m1_serf", MODE1, 16'h1234, 2'd1, 4'b1101, 1'b0, 16'hC0DE, 16'hC0DE, 522, 0, 0, 0);
        xfer("m2_serf", MODE2, 16'h6B59, 2'd3, 4'b0111, 1'b0, 16'h9E37, 16'h9E37, 506, 0, 0, 0);
        xfer("m0_pulses", MODE0, 16'h5AF0, 2'd2, 4'b1011, 1'b0, 16'h0FA5, 16'h0FA5, 506, 100, 505, 0);
        xfer("m1_chain", MODE1, 16'h0F0F, 2'd0, 4'b1110, 1'b0, 16'hF00F, 16'hF00F, 522, 0, 521, 0);
        xfer("m3_reset", MODE3, 16'hFFFF, 2'd2, 4'b1011, 1'b0, 16'h1111, 16'h0000, 0, 0, 0, 200);
        xfer("m0_after", MODE0, 16'h00FF, 2'd2, 4'b1011, 1'b0, 16'hAA55, 16'hAA55, 506, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
